// File: rtl/sos_tx_module.sv
// Morse "S O S" buzzer sequencer: one start pulse emits dot,dot,dot,dash,dash,dash,dot,dot,dot,
// each followed by a gap, timed by a 1 ms prescaler and a per-phase ms counter.
module sos_tx_module #(
  parameter logic [15:0] T1MS    = 16'd49_999,
  parameter logic [8:0]  DOT_MS  = 9'd100,
  parameter logic [8:0]  DASH_MS = 9'd300,
  parameter logic [8:0]  GAP_MS  = 9'd50
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic SOS_En_Sig,
  output logic Pin_Out,
  output logic Busy_Sig,
  output logic Done_Sig
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam logic [8:0] DOT_LAST  = DOT_MS - 9'd1;
  localparam logic [8:0] DASH_LAST = DASH_MS - 9'd1;
  localparam logic [8:0] GAP_LAST  = GAP_MS - 9'd1;
  localparam logic [3:0] LAST_IDX  = 4'd8;

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [15:0] pre_q;
  logic [8:0]  ms_q;
  logic        pin_q;
  logic        busy_q;
  logic        done_q;

  logic        ms_tick_d;
  logic        is_dash_d;
  logic [8:0]  on_last_d;
  logic        phase_end_d;

  // Phase-end detection: the last clock of the last ms of the current phase
  always_comb begin
    ms_tick_d   = (pre_q == T1MS);
    is_dash_d   = (idx_q >= 4'd3) && (idx_q <= 4'd5);
    on_last_d   = is_dash_d ? DASH_LAST : DOT_LAST;
    phase_end_d = 1'b0;
    case (state_q)
      ON:      phase_end_d = ms_tick_d && (ms_q == on_last_d);
      OFF:     phase_end_d = ms_tick_d && (ms_q == GAP_LAST);
      default: phase_end_d = 1'b0;
    endcase
  end

  // Sequencer FSM with counters and registered outputs
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      pre_q   <= 16'd0;
      ms_q    <= 9'd0;
      pin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          pre_q <= 16'd0;
          ms_q  <= 9'd0;
          if (SOS_En_Sig) begin
            state_q <= ON;
            idx_q   <= 4'd0;
            pin_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            pin_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        ON: begin
          if (phase_end_d) begin
            state_q <= OFF;
            pin_q   <= 1'b0;
            pre_q   <= 16'd0;
            ms_q    <= 9'd0;
          end else begin
            pre_q <= ms_tick_d ? 16'd0 : pre_q + 16'd1;
            ms_q  <= ms_tick_d ? ms_q + 9'd1 : ms_q;
          end
        end
        OFF: begin
          if (phase_end_d) begin
            pre_q <= 16'd0;
            ms_q  <= 9'd0;
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ON;
              idx_q   <= idx_q + 4'd1;
              pin_q   <= 1'b1;
            end
          end else begin
            pre_q <= ms_tick_d ? 16'd0 : pre_q + 16'd1;
            ms_q  <= ms_tick_d ? ms_q + 9'd1 : ms_q;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= 4'd0;
          pre_q   <= 16'd0;
          ms_q    <= 9'd0;
          pin_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Pin_Out  = pin_q;
  assign Busy_Sig = busy_q;
  assign Done_Sig = done_q;

endmodule

// File: tb/tb_sos_tx_module.sv
// Self-checking bench for sos_tx_module: timeline model of the SOS waveform plus directed
// literal checks (pulse widths, done timing, ignored starts, back-to-back start, mid-pattern reset).
module tb_sos_tx_module;

  localparam logic [15:0] T1MS    = 16'd4;
  localparam logic [8:0]  DOT_MS  = 9'd2;
  localparam logic [8:0]  DASH_MS = 9'd6;
  localparam logic [8:0]  GAP_MS  = 9'd1;

  localparam int MS_C   = int'(T1MS) + 1;
  localparam int DOT_C  = int'(DOT_MS) * MS_C;
  localparam int DASH_C = int'(DASH_MS) * MS_C;
  localparam int GAP_C  = int'(GAP_MS) * MS_C;
  localparam int TOTAL  = 6 * DOT_C + 3 * DASH_C + 9 * GAP_C;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic SOS_En_Sig = 1'b0;
  logic Pin_Out, Busy_Sig, Done_Sig;

  int checks = 0;
  int failures = 0;
  int off = -1;

  sos_tx_module #(
    .T1MS(T1MS), .DOT_MS(DOT_MS), .DASH_MS(DASH_MS), .GAP_MS(GAP_MS)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .SOS_En_Sig(SOS_En_Sig),
    .Pin_Out(Pin_Out), .Busy_Sig(Busy_Sig), .Done_Sig(Done_Sig)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Buzzer level at a given offset into the pattern, from the element timeline
  function automatic int exp_pin(input int o);
    int t;
    int len;
    t = 0;
    if (o < 0) return 0;
    for (int i = 0; i < 9; i++) begin
      len = (i >= 3 && i <= 5) ? DASH_C : DOT_C;
      if (o < t + len) return 1;
      t += len;
      if (o < t + GAP_C) return 0;
      t += GAP_C;
    end
    return 0;
  endfunction

  // Model: offset of the current cycle within the running pattern (-1 = none)
  always @(posedge CLK) begin
    if (!RSTn) begin
      off = -1;
    end else if ((off < 0 || off == TOTAL) && SOS_En_Sig) begin
      off = 0;
    end else if (off >= 0 && off < TOTAL) begin
      off = off + 1;
    end else begin
      off = -1;
    end
  end

  // Compare DUT outputs against the model every cycle
  always @(negedge CLK) begin
    if (!RSTn) begin
      check("rst_pin", int'(Pin_Out), 0);
      check("rst_busy", int'(Busy_Sig), 0);
      check("rst_done", int'(Done_Sig), 0);
    end else begin
      check("model_pin", int'(Pin_Out), exp_pin(off));
      check("model_busy", int'(Busy_Sig), (off >= 0 && off < TOTAL) ? 1 : 0);
      check("model_done", int'(Done_Sig), (off == TOTAL) ? 1 : 0);
    end
  end

  initial begin
    int widths[$];
    int exp_w[9];
    int cur;
    int busy_cnt;
    int done_cnt;
    int waited;
    bit found;

    exp_w = '{10, 10, 10, 30, 30, 30, 10, 10, 10};

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset_pin", int'(Pin_Out), 0);
    check("reset_busy", int'(Busy_Sig), 0);
    check("reset_done", int'(Done_Sig), 0);
    #2 RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_busy", int'(Busy_Sig), 0);

    // Single start at edge k, extra pulses at k+20 / k+100, restart coincident with done
    SOS_En_Sig = 1'b1;
    cur = 0; busy_cnt = 0; done_cnt = 0;
    for (int j = 1; j <= 200; j++) begin
      @(negedge CLK);
      SOS_En_Sig = (j == 20 || j == 100 || j == 196) ? 1'b1 : 1'b0;
      if (j == 1)  check("dot1_first_high", int'(Pin_Out), 1);
      if (j == 10) check("dot1_last_high", int'(Pin_Out), 1);
      if (j == 11) check("gap1_first_low", int'(Pin_Out), 0);
      if (j == 15) check("gap1_last_low", int'(Pin_Out), 0);
      if (j == 16) check("dot2_first_high", int'(Pin_Out), 1);
      if (j == 196) begin
        check("done_at_196", int'(Done_Sig), 1);
        check("busy_low_at_done", int'(Busy_Sig), 0);
      end
      if (j == 197) check("restart_busy", int'(Busy_Sig), 1);
      if (j <= 195) begin
        if (Pin_Out) cur++;
        else if (cur > 0) begin widths.push_back(cur); cur = 0; end
        if (Busy_Sig) busy_cnt++;
      end
      if (j <= 196 && Done_Sig) done_cnt++;
    end
    check("pulse_count", widths.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < widths.size()) check($sformatf("width_%0d", i), widths[i], exp_w[i]);
    end
    check("busy_clocks", busy_cnt, 195);
    check("done_pulses", done_cnt, 1);

    // Let the back-to-back pattern finish (bounded)
    found = 1'b0;
    for (int j = 0; j < 300 && !found; j++) begin
      @(negedge CLK);
      if (Done_Sig) found = 1'b1;
    end
    check("second_done_seen", int'(found), 1);
    repeat (3) @(negedge CLK);

    // Reset in the middle of the first dash
    SOS_En_Sig = 1'b1;
    for (int j = 1; j <= 50; j++) begin
      @(negedge CLK);
      SOS_En_Sig = 1'b0;
    end
    check("pre_reset_pin", int'(Pin_Out), 1);
    #2 RSTn = 1'b0;
    #1;
    check("abort_pin", int'(Pin_Out), 0);
    check("abort_busy", int'(Busy_Sig), 0);
    check("abort_done", int'(Done_Sig), 0);
    @(negedge CLK);
    #2 RSTn = 1'b1;
    done_cnt = 0;
    for (int j = 0; j < 250; j++) begin
      @(negedge CLK);
      if (Done_Sig) done_cnt++;
    end
    check("no_done_after_abort", done_cnt, 0);
    check("idle_after_abort", int'(Busy_Sig), 0);

    // Fresh start after abort: done must come exactly 196 cycles after acceptance
    SOS_En_Sig = 1'b1;
    found = 1'b0; waited = 0;
    for (int j = 1; j <= 250 && !found; j++) begin
      @(negedge CLK);
      SOS_En_Sig = 1'b0;
      if (Done_Sig) begin found = 1'b1; waited = j; end
    end
    check("restart_done_seen", int'(found), 1);
    check("restart_done_cycle", waited, TOTAL + 1);

    // Randomized starts with rare resets, checked by the model
    for (int j = 0; j < 3000; j++) begin
      @(negedge CLK);
      SOS_En_Sig = ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 999) == 0) begin
        #2 RSTn = 1'b0;
        @(negedge CLK);
        #2 RSTn = 1'b1;
      end
    end
    SOS_En_Sig = 1'b0;
    repeat (5) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
